// File: rtl/cond_flag_stage.sv
// rtl/cond_flag_stage.sv - ARM condition check, NZCV flag register and writeback latch
module cond_flag_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid,
   input  logic        stall,
   input  logic        flush,
   input  logic [3:0]  opCode,
   input  logic        sBit,
   input  logic [3:0]  cond,
   input  logic        shifterCarry,
   input  logic [3:0]  destReg,
   input  logic [31:0] result,
   input  logic        N,
   input  logic        Z,
   input  logic        C,
   input  logic        V,
   output logic [3:0]  flags,
   output logic        carryOut,
   output logic        condPass,
   output logic        wbValid,
   output logic [3:0]  wbReg,
   output logic [31:0] wbData,
   output logic        pcWrite
);

   logic [3:0]  flags_q, flags_d;
   logic        wb_valid_q, wb_valid_d;
   logic [3:0]  wb_reg_q;
   logic [31:0] wb_data_q;
   logic        pc_write_q, pc_write_d;

   logic        f_n, f_z, f_c, f_v;
   logic        is_test, is_arith, accept, flag_upd;

   assign f_n = flags_q[3];
   assign f_z = flags_q[2];
   assign f_c = flags_q[1];
   assign f_v = flags_q[0];

   // Condition is judged against the architectural flags only, never the ALU's live flags
   always_comb begin
      condPass = 1'b0;
      case (cond)
         4'b0000: condPass = f_z;
         4'b0001: condPass = ~f_z;
         4'b0010: condPass = f_c;
         4'b0011: condPass = ~f_c;
         4'b0100: condPass = f_n;
         4'b0101: condPass = ~f_n;
         4'b0110: condPass = f_v;
         4'b0111: condPass = ~f_v;
         4'b1000: condPass = f_c & ~f_z;
         4'b1001: condPass = ~f_c | f_z;
         4'b1010: condPass = (f_n == f_v);
         4'b1011: condPass = (f_n != f_v);
         4'b1100: condPass = ~f_z & (f_n == f_v);
         4'b1101: condPass = f_z | (f_n != f_v);
         4'b1110: condPass = 1'b1;
         default: condPass = 1'b0;
      endcase
   end

   // TST/TEQ/CMP/CMN only set flags; CMP/CMN take the full ALU NZCV like other arithmetic ops
   assign is_test  = (opCode[3:2] == 2'b10);
   assign is_arith = ((opCode >= 4'b0010) && (opCode <= 4'b0111)) ||
                     (opCode == 4'b1010) || (opCode == 4'b1011);
   assign accept   = valid & condPass & ~stall & ~flush;
   assign flag_upd = accept & (sBit | is_test);

   // Next-state for flags and writeback; logical ops take C from the shifter and keep V
   always_comb begin
      flags_d    = flags_q;
      wb_valid_d = accept & ~is_test;
      pc_write_d = accept & ~is_test & (destReg == 4'b1111);
      if (flag_upd) begin
         if (is_arith) begin
            flags_d = {N, Z, C, V};
         end else begin
            flags_d = {N, Z, shifterCarry, flags_q[0]};
         end
      end
   end

   // State registers: flush beats stall, stall freezes everything
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         flags_q    <= 4'b0000;
         wb_valid_q <= 1'b0;
         wb_reg_q   <= 4'b0000;
         wb_data_q  <= 32'h0;
         pc_write_q <= 1'b0;
      end else if (flush) begin
         wb_valid_q <= 1'b0;
         pc_write_q <= 1'b0;
      end else if (!stall) begin
         flags_q    <= flags_d;
         wb_valid_q <= wb_valid_d;
         wb_reg_q   <= destReg;
         wb_data_q  <= result;
         pc_write_q <= pc_write_d;
      end
   end

   assign flags    = flags_q;
   assign carryOut = flags_q[1];
   assign wbValid  = wb_valid_q;
   assign wbReg    = wb_reg_q;
   assign wbData   = wb_data_q;
   assign pcWrite  = pc_write_q;

endmodule

// File: tb/tb_cond_flag_stage.sv
// tb/tb_cond_flag_stage.sv - randomized model-checked bench for cond_flag_stage
module tb_cond_flag_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid, stall, flush, sBit, shifterCarry;
   logic [3:0]  opCode, cond, destReg;
   logic [31:0] result;
   logic        N, Z, C, V;
   logic [3:0]  flags;
   logic        carryOut, condPass, wbValid, pcWrite;
   logic [3:0]  wbReg;
   logic [31:0] wbData;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0]  m_flags;
   logic        m_wbv, m_pc;
   logic [3:0]  m_wbreg;
   logic [31:0] m_wbdata;

   cond_flag_stage dut (
      .clk(clk), .reset(reset), .valid(valid), .stall(stall), .flush(flush),
      .opCode(opCode), .sBit(sBit), .cond(cond), .shifterCarry(shifterCarry),
      .destReg(destReg), .result(result), .N(N), .Z(Z), .C(C), .V(V),
      .flags(flags), .carryOut(carryOut), .condPass(condPass),
      .wbValid(wbValid), .wbReg(wbReg), .wbData(wbData), .pcWrite(pcWrite)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ARM conditions come in pairs: even code tests a predicate, odd code its inverse
   function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] cd);
      logic n, z, c, v, base;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      if (cd == 4'd14) return 1'b1;
      if (cd == 4'd15) return 1'b0;
      case (cd >> 1)
         3'd0:    base = z;
         3'd1:    base = c;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = c && !z;
         3'd5:    base = (n == v);
         default: base = !z && (n == v);
      endcase
      return (cd % 2 == 1) ? !base : base;
   endfunction

   task automatic ref_reset();
      m_flags = 4'd0; m_wbv = 1'b0; m_pc = 1'b0; m_wbreg = 4'd0; m_wbdata = 32'd0;
   endtask

   task automatic ref_edge();
      logic acc, tst, ari;
      acc = valid && ref_cond(m_flags, cond) && !stall && !flush;
      tst = (opCode >= 8) && (opCode <= 11);
      ari = ((opCode >= 2) && (opCode <= 7)) || (opCode == 10) || (opCode == 11);
      if (flush) begin
         m_wbv = 1'b0;
         m_pc  = 1'b0;
      end else if (!stall) begin
         if (acc && (sBit || tst))
            m_flags = ari ? {N, Z, C, V} : {N, Z, shifterCarry, m_flags[0]};
         m_wbv    = acc && !tst;
         m_wbreg  = destReg;
         m_wbdata = result;
         m_pc     = m_wbv && (destReg == 15);
      end
   endtask

   task automatic compare_outputs();
      check("flags", flags, m_flags);
      check("carryOut", carryOut, m_flags[1]);
      check("wbValid", wbValid, m_wbv);
      check("pcWrite", pcWrite, m_pc);
      if (m_wbv) begin
         check("wbReg", wbReg, m_wbreg);
         check("wbData", wbData, m_wbdata);
      end
   endtask

   task automatic set_in(input logic v, input logic st, input logic fl, input logic [3:0] op,
                         input logic s, input logic [3:0] cd, input logic sc,
                         input logic [3:0] dr, input logic [31:0] res, input logic [3:0] nzcv);
      valid = v; stall = st; flush = fl; opCode = op; sBit = s; cond = cd;
      shifterCarry = sc; destReg = dr; result = res; {N, Z, C, V} = nzcv;
   endtask

   // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one
   task automatic cycle();
      #1;
      check("condPass", condPass, ref_cond(m_flags, cond));
      @(posedge clk);
      #1;
      ref_edge();
      compare_outputs();
   endtask

   task automatic mid_reset();
      #1 reset = 1'b1;
      #1;
      ref_reset();
      check("rst_flags", flags, 4'd0);
      check("rst_wbValid", wbValid, 1'b0);
      check("rst_wbReg", wbReg, 4'd0);
      check("rst_wbData", wbData, 32'd0);
      check("rst_pcWrite", pcWrite, 1'b0);
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      set_in(0, 0, 0, 4'd0, 0, 4'd0, 0, 4'd0, 32'd0, 4'd0);
      ref_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_flags", flags, 4'd0);
      check("reset_wbValid", wbValid, 1'b0);
      check("reset_pcWrite", pcWrite, 1'b0);
      check("reset_wbData", wbData, 32'd0);
      reset = 1'b0;

      // CMP under AL: flags load from ALU, no writeback
      set_in(1, 0, 0, 4'b1010, 0, 4'b1110, 0, 4'd7, 32'h55, 4'b0110);
      cycle();
      check("d034_flags", flags, 4'b0110);
      check("d034_wbValid", wbValid, 1'b0);

      // EQ passes with Z=1; ADD without S writes back only
      set_in(1, 0, 0, 4'b0100, 0, 4'b0000, 0, 4'd3, 32'h12, 4'b1001);
      #1 check("d035_condPass", condPass, 1'b1);
      cycle();
      check("d035_wbValid", wbValid, 1'b1);
      check("d035_wbReg", wbReg, 4'd3);
      check("d035_wbData", wbData, 32'h12);
      check("d035_flags", flags, 4'b0110);

      // NE fails: nothing changes even with S
      set_in(1, 0, 0, 4'b0100, 1, 4'b0001, 1, 4'd4, 32'h99, 4'b1111);
      #1 check("d036_condPass", condPass, 1'b0);
      cycle();
      check("d036_wbValid", wbValid, 1'b0);
      check("d036_flags", flags, 4'b0110);

      // SUBS to reach 0001, then MOVS keeps V and takes C from the shifter
      set_in(1, 0, 0, 4'b0010, 1, 4'b1110, 0, 4'd1, 32'h0, 4'b0001);
      cycle();
      check("d037_pre", flags, 4'b0001);
      set_in(1, 0, 0, 4'b1101, 1, 4'b1110, 1, 4'd2, 32'h8000_0000, 4'b1000);
      cycle();
      check("d037_flags", flags, 4'b1011);

      // Write to PC held under stall, released, then flush overrides stall
      set_in(1, 1, 0, 4'b1101, 0, 4'b1110, 0, 4'd15, 32'h100, 4'b0000);
      cycle();
      check("d038_hold1_wbReg", wbReg, 4'd2);
      cycle();
      check("d038_hold2_wbValid", wbValid, 1'b1);
      check("d038_hold2_pcWrite", pcWrite, 1'b0);
      stall = 1'b0;
      cycle();
      check("d038_wbValid", wbValid, 1'b1);
      check("d038_pcWrite", pcWrite, 1'b1);
      check("d038_wbData", wbData, 32'h100);
      stall = 1'b1; flush = 1'b1;
      cycle();
      check("d038_flush_wbValid", wbValid, 1'b0);
      check("d038_flush_pcWrite", pcWrite, 1'b0);

      // Reach flags=1111 with a pending writeback, then reset asynchronously
      set_in(1, 0, 0, 4'b0010, 1, 4'b1110, 0, 4'd5, 32'hDEAD_BEEF, 4'b1111);
      cycle();
      check("d039_pre_flags", flags, 4'b1111);
      check("d039_pre_wbValid", wbValid, 1'b1);
      mid_reset();

      // Random traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         set_in(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 9) == 0), 4'($urandom), 1'($urandom),
                4'($urandom), 1'($urandom), 4'($urandom), $urandom, 4'($urandom));
         cycle();
         if ($urandom_range(0, 99) == 0) mid_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
